// File: rtl/dot_scan_controller.sv
// Dot-matrix scan controller: walks row/column addresses, waits for the
// address to settle, then pulses the motor drive for dots the sequencer enables.
module dot_scan_controller #(
   parameter int MEM_LENGTH         = 128,
   parameter int MEM_ADDRESS_LENGTH = 7
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          loop_en,
   input  logic [MEM_ADDRESS_LENGTH-1:0] last_row,
   input  logic [MEM_ADDRESS_LENGTH-1:0] last_col,
   input  logic [7:0]                    settle_cycles,
   input  logic [15:0]                   fire_cycles,
   input  logic                          firing_bit,
   input  logic                          firing_data,
   output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
   output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
   output logic                          drive_en,
   output logic                          drive_pol,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int AW = MEM_ADDRESS_LENGTH;

   typedef enum logic [2:0] {IDLE, SETTLE, FIRE, NEXT, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   row_q, row_d, col_q, col_d;
   logic [AW-1:0]   last_row_q, last_row_d, last_col_q, last_col_d;
   logic [7:0]      settle_q, settle_d;
   logic [15:0]     fire_q, fire_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            pol_q, pol_d;
   logic            drive_en_q, drive_en_d;
   logic            drive_pol_q, drive_pol_d;
   logic            load_cfg;

   function automatic logic [AW-1:0] clamp_idx(input logic [AW-1:0] idx);
      if (int'(idx) >= MEM_LENGTH) return AW'(MEM_LENGTH - 1);
      return idx;
   endfunction

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      last_row_d = last_row_q;
      last_col_d = last_col_q;
      settle_d   = settle_q;
      fire_d     = fire_q;
      cnt_d      = cnt_q;
      pol_d      = pol_q;
      load_cfg   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               load_cfg = 1'b1;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            // The sequencer's dot bits are only trusted once the address has settled.
            if (cnt_q == {8'd0, settle_q}) begin
               pol_d   = firing_data;
               cnt_d   = 16'd0;
               state_d = firing_bit ? FIRE : NEXT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         FIRE: begin
            if (cnt_q == fire_q) begin
               cnt_d   = 16'd0;
               state_d = NEXT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         NEXT: begin
            if (row_q == last_row_q && col_q == last_col_q) begin
               state_d = DONE;
            end else begin
               state_d = SETTLE;
               cnt_d   = 16'd0;
               if (col_q < last_col_q) begin
                  col_d = col_q + 1'b1;
               end else begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (loop_en) begin
               load_cfg = 1'b1;
               state_d  = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_cfg) begin
         last_row_d = clamp_idx(last_row);
         last_col_d = clamp_idx(last_col);
         settle_d   = settle_cycles;
         fire_d     = fire_cycles;
         row_d      = '0;
         col_d      = '0;
         cnt_d      = 16'd0;
      end

      if (abort) begin
         state_d = IDLE;
         row_d   = '0;
         col_d   = '0;
         cnt_d   = 16'd0;
      end

      // Drive outputs are registered from the next state so they line up with FIRE exactly.
      drive_en_d  = (state_d == FIRE);
      drive_pol_d = drive_en_d & pol_d;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         last_row_q  <= '0;
         last_col_q  <= '0;
         settle_q    <= 8'd0;
         fire_q      <= 16'd0;
         cnt_q       <= 16'd0;
         pol_q       <= 1'b0;
         drive_en_q  <= 1'b0;
         drive_pol_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         last_row_q  <= last_row_d;
         last_col_q  <= last_col_d;
         settle_q    <= settle_d;
         fire_q      <= fire_d;
         cnt_q       <= cnt_d;
         pol_q       <= pol_d;
         drive_en_q  <= drive_en_d;
         drive_pol_q <= drive_pol_d;
      end
   end

   assign row_select = row_q;
   assign col_select = col_q;
   assign drive_en   = drive_en_q;
   assign drive_pol  = drive_pol_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_dot_scan_controller.sv
// Bench for dot_scan_controller: a frame-level model predicts every drive pulse
// and each frame's busy length; a monitor compares what the controller emits.
module tb_dot_scan_controller;

   localparam int ML = 128;
   localparam int AW = 7;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          loop_en = 1'b0;
   logic [AW-1:0] last_row = '0;
   logic [AW-1:0] last_col = '0;
   logic [7:0]    settle_cycles = 8'd0;
   logic [15:0]   fire_cycles = 16'd0;
   logic          firing_bit;
   logic          firing_data;
   logic [AW-1:0] row_select;
   logic [AW-1:0] col_select;
   logic          drive_en;
   logic          drive_pol;
   logic          busy;
   logic          frame_done;

   bit map_bit [ML][ML];
   bit map_pol [ML][ML];

   typedef struct {
      bit is_frame;
      int r;
      int c;
      int pol;
      int w;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   dot_scan_controller #(.MEM_LENGTH(ML), .MEM_ADDRESS_LENGTH(AW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .loop_en(loop_en), .last_row(last_row), .last_col(last_col),
      .settle_cycles(settle_cycles), .fire_cycles(fire_cycles),
      .firing_bit(firing_bit), .firing_data(firing_data),
      .row_select(row_select), .col_select(col_select),
      .drive_en(drive_en), .drive_pol(drive_pol),
      .busy(busy), .frame_done(frame_done)
   );

   // The sequencer answers combinationally for whatever dot is addressed.
   assign firing_bit  = map_bit[row_select][col_select];
   assign firing_data = map_pol[row_select][col_select];

   always #5 clock = ~clock;

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation still running after 90000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int clampi(input int v);
      return (v >= ML) ? ML - 1 : v;
   endfunction

   // mode 0: random dots, 1: every dot fires with polarity 1, 2: no dot fires
   task automatic fill_map(input int lr, input int lc, input int mode);
      for (int r = 0; r <= lr; r++)
         for (int c = 0; c <= lc; c++) begin
            map_bit[r][c] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom);
            map_pol[r][c] = (mode == 1) ? 1'b1 : 1'($urandom);
         end
   endtask

   task automatic push_frame(input int lr_in, input int lc_in, input int s, input int f);
      int lr = clampi(lr_in);
      int lc = clampi(lc_in);
      int busy_n = 1;
      for (int r = 0; r <= lr; r++)
         for (int c = 0; c <= lc; c++) begin
            busy_n += s + 2;
            if (map_bit[r][c]) begin
               busy_n += f + 1;
               exp_q.push_back('{1'b0, r, c, int'(map_pol[r][c]), f + 1});
            end
         end
      exp_q.push_back('{1'b1, 0, 0, 0, busy_n});
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!frame_done && n < budget) begin
         tick();
         n++;
      end
      chk("frame_done_seen", frame_done, 1);
   endtask

   task automatic wait_drive(input int budget);
      int n = 0;
      while (!drive_en && n < budget) begin
         tick();
         n++;
      end
      chk("drive_seen", drive_en, 1);
   endtask

   task automatic run_frame(input int lr, input int lc, input int s, input int f,
                            input bit lp, input bit scramble);
      last_row      = AW'(lr);
      last_col      = AW'(lc);
      settle_cycles = 8'(s);
      fire_cycles   = 16'(f);
      loop_en       = lp;
      push_frame(lr, lc, s, f);
      if (lp) push_frame(lr, lc, s, f);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (scramble) begin
         tick();
         tick();
         settle_cycles = 8'($urandom);
         fire_cycles   = 16'($urandom_range(0, 7));
         last_row      = AW'($urandom);
         last_col      = AW'($urandom);
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      if (lp) begin
         wait_done(5000);
         tick();
         chk("loop_restart_busy", busy, 1);
         chk("loop_restart_row", row_select, 0);
         chk("loop_restart_col", col_select, 0);
         loop_en = 1'b0;
      end
      wait_idle(70000);
      tick();
   endtask

   // Monitor: reconstructs drive pulses and frame completions from the pins.
   initial begin
      bit in_pulse = 1'b0;
      bit p_bad = 1'b0;
      bit pol_idle_bad = 1'b0;
      int p_r = 0, p_c = 0, p_pol = 0, p_w = 0;
      int busy_run = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            in_pulse = 1'b0;
            busy_run = 0;
         end else begin
            if (busy) busy_run++;
            if (!drive_en && drive_pol) pol_idle_bad = 1'b1;
            if (drive_en) begin
               if (!in_pulse) begin
                  in_pulse = 1'b1;
                  p_bad = 1'b0;
                  p_r = int'(row_select);
                  p_c = int'(col_select);
                  p_pol = int'(drive_pol);
                  p_w = 1;
               end else begin
                  p_w++;
                  if (int'(drive_pol) != p_pol || int'(row_select) != p_r ||
                      int'(col_select) != p_c) p_bad = 1'b1;
               end
            end else if (in_pulse) begin
               in_pulse = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_pulse", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("pulse_order", e.is_frame, 0);
                  if (!e.is_frame) begin
                     chk("pulse_row", p_r, e.r);
                     chk("pulse_col", p_c, e.c);
                     chk("pulse_pol", p_pol, e.pol);
                     chk("pulse_width", p_w, e.w);
                     chk("pulse_stable", p_bad, 0);
                  end
               end
            end
            if (frame_done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_order", e.is_frame, 1);
                  if (e.is_frame) chk("frame_busy_cycles", busy_run, e.w);
                  chk("pol_outside_fire", pol_idle_bad, 0);
               end
               busy_run = 0;
            end
            if (!busy) busy_run = 0;
         end
      end
   end

   initial begin
      int lr, lc, fd_seen;
      tick();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_drive_en", drive_en, 0);
      chk("rst_drive_pol", drive_pol, 0);
      chk("rst_row", row_select, 0);
      chk("rst_col", col_select, 0);
      chk("rst_frame_done", frame_done, 0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      tick();

      // two firing dots on one row
      fill_map(0, 1, 1);
      run_frame(0, 1, 0, 2, 1'b0, 1'b0);
      // 2x2 frame where nothing fires
      fill_map(1, 1, 2);
      run_frame(1, 1, 1, 5, 1'b0, 1'b0);
      // random frames with config scrambled mid-frame and a stray start
      for (int i = 0; i < 6; i++) begin
         lr = $urandom_range(1, 3);
         lc = $urandom_range(0, 5);
         fill_map(lr, lc, 0);
         run_frame(lr, lc, $urandom_range(0, 4), $urandom_range(0, 5), 1'b0, 1'b1);
      end
      // full-width row wrap with automatic restart
      fill_map(1, 127, 0);
      map_bit[0][127] = 1'b1;
      map_bit[1][0]   = 1'b1;
      run_frame(1, 127, 0, 0, 1'b1, 1'b0);
      // counter extremes
      fill_map(0, 0, 1);
      run_frame(0, 0, 255, 1, 1'b0, 1'b0);
      run_frame(0, 0, 0, 65535, 1'b0, 1'b0);

      // abort during FIRE
      chk("queue_drained_before_abort", exp_q.size(), 0);
      mon_en = 1'b0;
      last_row = '0; last_col = '0; settle_cycles = 8'd0; fire_cycles = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_drive(50);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_drive_en", drive_en, 0);
      chk("abort_drive_pol", drive_pol, 0);
      chk("abort_busy", busy, 0);
      chk("abort_row", row_select, 0);
      chk("abort_col", col_select, 0);
      fd_seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (frame_done) fd_seen++;
         tick();
      end
      chk("abort_no_frame_done", fd_seen, 0);

      // abort beats start in IDLE
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_over_start", busy, 0);

      // reset during FIRE
      fire_cycles = 16'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_drive(50);
      tick();
      reset_n = 1'b0;
      tick();
      chk("rst_fire_drive_en", drive_en, 0);
      chk("rst_fire_busy", busy, 0);
      reset_n = 1'b1;
      tick();

      // reset during SETTLE together with start
      settle_cycles = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      start = 1'b1;
      tick();
      chk("rst_settle_busy", busy, 0);
      chk("rst_settle_drive_en", drive_en, 0);
      chk("rst_settle_drive_pol", drive_pol, 0);
      chk("rst_settle_row", row_select, 0);
      chk("rst_settle_col", col_select, 0);
      chk("rst_settle_frame_done", frame_done, 0);
      reset_n = 1'b1;
      start = 1'b0;
      tick();
      mon_en = 1'b1;
      fill_map(1, 2, 0);
      run_frame(1, 2, 2, 3, 1'b0, 1'b0);

      repeat (5) tick();
      chk("expectations_left", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dot_scan_controller.md
DOT_SCAN_CONTROLLER -- requirements
Module: dot_scan_controller

Interface
REQ-001 SHALL have parameter MEM_LENGTH, default 128, number of rows and columns in the dot matrix.
REQ-002 SHALL have parameter MEM_ADDRESS_LENGTH, default 7, width of row/column indices.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset, sampled on rising clock.
REQ-005 SHALL have port start  input  1  in IDLE, begins a scan frame.
REQ-006 SHALL have port abort  input  1  terminates any scan and returns to IDLE.
REQ-007 SHALL have port loop_en  input  1  when 1 at frame end, the next frame starts automatically.
REQ-008 SHALL have port last_row  input  MEM_ADDRESS_LENGTH  index of the final row scanned.
REQ-009 SHALL have port last_col  input  MEM_ADDRESS_LENGTH  index of the final column scanned.
REQ-010 SHALL have port settle_cycles  input  8  extra wait cycles after each address change.
REQ-011 SHALL have port fire_cycles  input  16  drive pulse width minus one.
REQ-012 SHALL have port firing_bit  input  1  dot-enable bit from the sequencer for the current row/col.
REQ-013 SHALL have port firing_data  input  1  dot drive-polarity bit from the sequencer.
REQ-014 SHALL have port row_select  output  MEM_ADDRESS_LENGTH  registered row index to the sequencer.
REQ-015 SHALL have port col_select  output  MEM_ADDRESS_LENGTH  registered column index to the sequencer.
REQ-016 SHALL have port drive_en  output  1  registered motor drive enable.
REQ-017 SHALL have port drive_pol  output  1  registered polarity; valid when drive_en=1, else 0.
REQ-018 SHALL have port busy  output  1  1 in every state except IDLE.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse at completion of a frame.

Function
REQ-020 SHALL implement states IDLE, SETTLE, FIRE, NEXT, DONE.
REQ-021 IDLE with start=1 SHALL latch last_row, last_col, settle_cycles and fire_cycles, set row_select=col_select=0, and enter SETTLE; config changes during a frame SHALL be ignored.
REQ-022 SETTLE SHALL last exactly latched settle_cycles+1 cycles; in its final cycle firing_bit and firing_data SHALL be sampled.
REQ-023 Sampled firing_bit=1 SHALL enter FIRE; sampled firing_bit=0 SHALL enter NEXT directly, with drive_en staying 0.
REQ-024 FIRE SHALL last exactly latched fire_cycles+1 cycles with drive_en=1 and drive_pol=sampled firing_data during every FIRE cycle, then enter NEXT.
REQ-025 NEXT SHALL last one cycle; if col_select<last_col then col_select+1, else col_select=0 and row_select+1; then SETTLE.
REQ-026 NEXT at row_select=last_row and col_select=last_col SHALL enter DONE with row/col unchanged instead of wrapping.
REQ-027 DONE SHALL last one cycle with frame_done=1; then with loop_en=1 it SHALL reload config, set row/col to 0 and enter SETTLE, else it SHALL enter IDLE.
REQ-028 last_col/last_row values >= MEM_LENGTH SHALL be clamped to MEM_LENGTH-1 at latch time.
REQ-029 abort=1 in any state SHALL force IDLE on that edge, with drive_en=0, drive_pol=0 and row/col=0; it SHALL take priority over start and loop_en, and no frame_done SHALL be issued.
REQ-030 start while busy SHALL be ignored.
REQ-031 Counters SHALL not overflow: settle_cycles=255 SHALL give 256 cycles and fire_cycles=65535 SHALL give 65536 cycles.
REQ-032 drive_en SHALL never be 1 in SETTLE, NEXT, DONE or IDLE.

Reset
REQ-033 reset_n=0 SHALL, at the clock edge, force IDLE, row_select=0, col_select=0, drive_en=0, drive_pol=0, busy=0 and frame_done=0, clear all latched config and counters, and override all other inputs.
REQ-034 Reset asserted mid-FIRE SHALL drop drive_en at that same edge.

Verification
REQ-035 Scenario: last_row=0, last_col=1, settle=0, fire=2, firing_bit=1, firing_data=1 -> two drive_en pulses of 3 cycles each with drive_pol=1, col 0 then 1, frame_done one cycle, then IDLE; total 11 busy cycles.
REQ-036 Scenario: firing_bit=0 everywhere, 2x2 frame, settle=1 -> drive_en stays 0, each dot takes 3 cycles, frame_done after 12 busy cycles.
REQ-037 Scenario: last_col=127, last_row=1, loop_en=1 -> col wraps 127->0 with row 0->1, DONE then restart at (0,0) without returning to IDLE.
REQ-038 Scenario: abort asserted in cycle 2 of a 10-cycle FIRE -> drive_en=0 next cycle, busy=0, no frame_done.
REQ-039 Scenario: reset_n=0 during SETTLE plus start=1 on the same edge -> IDLE with all outputs 0; start one cycle after reset release begins a normal frame.
REQ-040 Scenario: settle_cycles changed mid-frame -> dot timing keeps the latched value until the next start or loop reload.
